sp_pack_fifo: RTL and testbench
===============================

Name: sp_pack_fifo

Overview:
- Single-clock serial-to-parallel packing FIFO, the parametrised successor to the two-stage 1-to-16 converter.
- Packs IN_W-bit beats into OUT_W-bit words through a packer register, then stores the words in a DEPTH-word circular buffer.
- Adds bit-order selection, flush of partial words with zero padding, and sticky overflow/underflow flags.
- Sits between the ADC bitstream capture and the 16-bit host read path.

Parameters:
- IN_W, 1, input beat width; OUT_W must be an integer multiple of IN_W.
- OUT_W, 16, output word width; RATIO = OUT_W/IN_W beats per word.
- DEPTH, 64, storage depth in OUT_W words; must be a power of 2 and >= 2.
- MSB_FIRST, 1, 1 = first beat lands in the top IN_W bits of the word; 0 = first beat lands in the bottom IN_W bits.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  IN_W  input beat.
- wr_en  in  1  beat valid.
- flush  in  1  push the pending partial word, zero-padded.
- rd_en  in  1  read request.
- dout  out  OUT_W  read data, registered.
- full  out  1  storage holds DEPTH words.
- empty  out  1  storage holds 0 words.
- word_count  out  $clog2(DEPTH)+1  number of stored words.
- pending  out  $clog2(RATIO)+1  number of beats held in the packer.
- overflow  out  1  sticky: a write or flush was dropped.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async assert, sync release): dout=0, full=0, empty=1, word_count=0, pending=0, overflow=0, underflow=0. Pointers and packer clear. Storage contents are don't-care.
- A mid-operation reset discards stored words and the partial word immediately, with no flush.
- Beat accept: when wr_en=1 and full=0, din enters the packer and pending increments.
  - On the RATIO-th beat, the completed word is pushed to storage in the same edge and pending returns to 0.
  - word_count/empty reflect the push on the next cycle.
- Bit order:
  - MSB_FIRST=1: beat k (0-based) occupies bits [OUT_W-1-k*IN_W -: IN_W].
  - MSB_FIRST=0: beat k occupies bits [k*IN_W +: IN_W].
- Write while full: the beat is dropped, overflow is set, and the packer is unchanged. full is evaluated on the registered count only, so an rd_en in the same cycle does not rescue the beat.
- Flush with pending>0 and full=0:
  - The word is pushed with unfilled positions = 0, and pending returns to 0.
  - If wr_en is also valid that cycle, the beat is included before the push. If that beat completes the word, exactly one word is pushed.
- Flush with pending=0 (and no wr_en): no-op.
- Flush while full: the packer is kept intact and overflow is set; the caller retries.
- Read:
  - rd_en=1 and empty=0: dout updates with the oldest word on the next edge (1-cycle latency), the read pointer advances, and word_count decrements.
  - rd_en=1 and empty=1: dout holds, underflow is set, and no pointer moves.
- Simultaneous push and read: word_count is unchanged, and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
  - The count is a separate up/down counter with +1, -1, or 0 per cycle.
- overflow and underflow clear only on rst.

Decomposition:
- Shared package sp_fifo_pkg holds:
  - a clog2 function;
  - parameter legality checks (OUT_W%IN_W==0, DEPTH power of 2);
  - localparams RATIO, AW=$clog2(DEPTH), CW=AW+1, PW=$clog2(RATIO)+1.
- One sub-module, sp_packer: the shift/insert register, pending counter, MSB/LSB placement, and flush padding. It emits a one-cycle push strobe plus the word.
- The storage RAM, pointers, and flags stay in the top level.

Test Plan:
- IN_W=1, OUT_W=16, MSB_FIRST=1: write bit pattern of 0xA5C3 MSB first -> after 16 beats, word_count=1. rd_en -> dout=0xA5C3 on the next cycle. MSB_FIRST=0 with the same beat sequence -> dout=0xC3A5 bit-reversed (0xC3A5 for reversed order).
- Write 5 beats all 1, then flush -> pushed word 0xF800 (MSB_FIRST=1), pending=0, word_count=1. A flush with pending=0 -> word_count unchanged.
- DEPTH=4: fill with 4 words (0x0001..0x0004) -> full=1. Write 16 more beats -> overflow=1 and word_count=4. Read all -> 0x0001..0x0004 in order, then empty=1.
- Read while empty -> underflow=1, dout unchanged. Sticky flags survive further traffic; assert rst -> all outputs return to reset values within the same cycle (async).
- Continuous write and read for 3×DEPTH words, so pointers wrap -> data in order, word_count steady. The push-and-read cycle leaves the count unchanged.
- Assert rst with pending=7 and word_count=2 -> after release, pending=0, empty=1. A new 16-beat word reads back correctly.

Source files
------------

// File: rtl/sp_fifo_pkg.sv
// Shared definitions for the serial-to-parallel packing FIFO: default sizing,
// width helpers, parameter legality check and the occupancy-update encoding.
package sp_fifo_pkg;

    localparam int DEF_IN_W      = 1;
    localparam int DEF_OUT_W     = 16;
    localparam int DEF_DEPTH     = 64;
    localparam int DEF_MSB_FIRST = 1;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_POP  = 2'b01,
        CNT_PUSH = 2'b10,
        CNT_BOTH = 2'b11
    } cnt_op_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit params_legal(input int in_w, input int out_w, input int depth);
        return (in_w > 0) && (out_w >= in_w) && ((out_w % in_w) == 0) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sp_fifo_packer.sv
// Beat packer: places IN_W-bit beats into an OUT_W-bit word and emits a
// combinational push strobe with the finished (or zero-padded) word.
module sp_packer
    import sp_fifo_pkg::*;
#(
    parameter  int IN_W      = DEF_IN_W,
    parameter  int OUT_W     = DEF_OUT_W,
    parameter  int MSB_FIRST = DEF_MSB_FIRST,
    localparam int RATIO     = OUT_W / IN_W,
    localparam int PW        = clog2(RATIO) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  din,
    input  logic             wr_en,
    input  logic             flush,
    input  logic             full,
    output logic             push,
    output logic [OUT_W-1:0] word,
    output logic [PW-1:0]    pending
);

    logic [OUT_W-1:0] word_q;
    logic [OUT_W-1:0] word_ins;
    logic [PW-1:0]    pend_q;
    logic [PW-1:0]    pend_ins;
    logic             beat_ok;
    logic             flush_ok;

    // Unfilled slots of word_q are always zero, so a flush pads for free.
    always_comb begin
        beat_ok  = wr_en && !full;
        flush_ok = flush && !full;
        word_ins = word_q;
        for (int k = 0; k < RATIO; k++) begin
            if (beat_ok && (pend_q == PW'(k))) begin
                if (MSB_FIRST != 0) word_ins[OUT_W-1-k*IN_W -: IN_W] = din;
                else                word_ins[k*IN_W +: IN_W]         = din;
            end
        end
        pend_ins = pend_q + PW'(beat_ok);
        push     = (pend_ins == PW'(RATIO)) || (flush_ok && (pend_ins != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            pend_q <= '0;
        end else if (push) begin
            word_q <= '0;
            pend_q <= '0;
        end else begin
            word_q <= word_ins;
            pend_q <= pend_ins;
        end
    end

    assign word    = word_ins;
    assign pending = pend_q;

endmodule

// File: rtl/sp_pack_fifo.sv
// Serial-to-parallel packing FIFO: beat packer feeding a DEPTH-word circular
// buffer with registered read data and sticky overflow/underflow flags.
module sp_pack_fifo
    import sp_fifo_pkg::*;
#(
    parameter  int IN_W      = DEF_IN_W,
    parameter  int OUT_W     = DEF_OUT_W,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int MSB_FIRST = DEF_MSB_FIRST,
    localparam int RATIO     = OUT_W / IN_W,
    localparam int AW        = clog2(DEPTH),
    localparam int CW        = AW + 1,
    localparam int PW        = clog2(RATIO) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  din,
    input  logic             wr_en,
    input  logic             flush,
    input  logic             rd_en,
    output logic [OUT_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    word_count,
    output logic [PW-1:0]    pending,
    output logic             overflow,
    output logic             underflow
);

    if (!params_legal(IN_W, OUT_W, DEPTH)) begin : g_bad_params
        $error("sp_pack_fifo: OUT_W must be a multiple of IN_W and DEPTH a power of 2 >= 2");
    end

    logic             push;
    logic [OUT_W-1:0] push_word;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             rd_ok;
    cnt_op_e          cnt_op;

    sp_packer #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .wr_en   (wr_en),
        .flush   (flush),
        .full    (full),
        .push    (push),
        .word    (push_word),
        .pending (pending)
    );

    // Flags come from the registered count, so a same-cycle read never frees room.
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign word_count = count_q;
    assign rd_ok      = rd_en && !empty;

    always_comb begin
        cnt_op = CNT_HOLD;
        case ({push, rd_ok})
            2'b01:   cnt_op = CNT_POP;
            2'b10:   cnt_op = CNT_PUSH;
            2'b11:   cnt_op = CNT_BOTH;
            default: cnt_op = CNT_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (rd_ok) begin
            dout <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case (cnt_op)
                CNT_PUSH: count_q <= count_q + CW'(1);
                CNT_POP:  count_q <= count_q - CW'(1);
                default:  count_q <= count_q;
            endcase
            if ((wr_en || flush) && full) overflow <= 1'b1;
            if (rd_en && empty)           underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sp_pack_fifo.sv
// Bench for sp_pack_fifo: two instances (MSB-first and LSB-first) share one
// stimulus stream and are checked against a queue-based reference model.
module tb_sp_pack_fifo;

    localparam int IN_W  = 1;
    localparam int OUT_W = 16;
    localparam int DEPTH = 4;
    localparam int RATIO = OUT_W / IN_W;

    logic            clk;
    logic            rst;
    logic [IN_W-1:0] din;
    logic            wr_en;
    logic            flush;
    logic            rd_en;

    logic [15:0] dout_m, dout_l;
    logic        full_m, full_l, empty_m, empty_l;
    logic [2:0]  wc_m, wc_l;
    logic [4:0]  pend_m, pend_l;
    logic        ovf_m, ovf_l, unf_m, unf_l;

    int n_pass  = 0;
    int n_total = 0;

    sp_pack_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .flush(flush), .rd_en(rd_en),
        .dout(dout_m), .full(full_m), .empty(empty_m), .word_count(wc_m),
        .pending(pend_m), .overflow(ovf_m), .underflow(unf_m)
    );

    sp_pack_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .flush(flush), .rd_en(rd_en),
        .dout(dout_l), .full(full_l), .empty(empty_l), .word_count(wc_l),
        .pending(pend_l), .overflow(ovf_l), .underflow(unf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: beats collect in a list; a word holds both bit orders {msb, lsb}.
    logic        m_beats[$];
    logic [31:0] m_words[$];
    logic [15:0] exp_dout_m, exp_dout_l;
    logic        exp_ovf, exp_unf;

    task automatic model_reset();
        m_beats.delete();
        m_words.delete();
        exp_dout_m = '0;
        exp_dout_l = '0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
    endtask

    function automatic logic [31:0] pack_beats();
        logic [15:0] mw, lw;
        mw = '0;
        lw = '0;
        for (int k = 0; k < m_beats.size(); k++) begin
            mw[15-k] = m_beats[k];
            lw[k]    = m_beats[k];
        end
        return {mw, lw};
    endfunction

    task automatic model_cycle(input logic w, input logic d, input logic f, input logic r);
        bit          was_full, was_empty;
        logic [31:0] x;
        was_full  = (m_words.size() == DEPTH);
        was_empty = (m_words.size() == 0);
        if (r) begin
            if (!was_empty) begin
                x = m_words.pop_front();
                exp_dout_m = x[31:16];
                exp_dout_l = x[15:0];
            end else begin
                exp_unf = 1'b1;
            end
        end
        if (w) begin
            if (was_full) exp_ovf = 1'b1;
            else begin
                m_beats.push_back(d);
                if (m_beats.size() == RATIO) begin
                    m_words.push_back(pack_beats());
                    m_beats.delete();
                end
            end
        end
        if (f) begin
            if (was_full) exp_ovf = 1'b1;
            else if (m_beats.size() != 0) begin
                m_words.push_back(pack_beats());
                m_beats.delete();
            end
        end
    endtask

    task automatic step(input logic w, input logic d, input logic f, input logic r);
        @(negedge clk);
        wr_en = w;
        din   = d;
        flush = f;
        rd_en = r;
        model_cycle(w, d, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if ({dout_m, dout_l} !== 32'h0) $display("FAIL reset_dout: got %h/%h want 0000/0000", dout_m, dout_l);
        else n_pass++;
        n_total++;
        if ({full_m, empty_m, wc_m, pend_m} !== {1'b0, 1'b1, 3'd0, 5'd0})
            $display("FAIL reset_status: got full=%b empty=%b wc=%0d pend=%0d want 0 1 0 0", full_m, empty_m, wc_m, pend_m);
        else n_pass++;
        n_total++;
        if ({ovf_m, unf_m, ovf_l, unf_l} !== 4'b0000) $display("FAIL reset_flags: got %b%b%b%b want 0000", ovf_m, unf_m, ovf_l, unf_l);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bit_order();
        logic [15:0] pat;
        pat = 16'hA5C3;
        for (int k = 0; k < 16; k++) step(1'b1, pat[15-k], 1'b0, 1'b0);
        n_total++;
        if (wc_m !== 3'd1 || pend_m !== 5'd0) $display("FAIL order_count: got wc=%0d pend=%0d want 1 0", wc_m, pend_m);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (dout_m !== 16'hA5C3) $display("FAIL order_msb: got %h want a5c3", dout_m);
        else n_pass++;
        n_total++;
        if (dout_l !== 16'hC3A5) $display("FAIL order_lsb: got %h want c3a5", dout_l);
        else n_pass++;
        n_total++;
        if (empty_m !== 1'b1) $display("FAIL order_empty: got %b want 1", empty_m);
        else n_pass++;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (pend_m !== 5'd5) $display("FAIL flush_pend5: got %0d want 5", pend_m);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (pend_m !== 5'd0 || wc_m !== 3'd1) $display("FAIL flush_push: got pend=%0d wc=%0d want 0 1", pend_m, wc_m);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (wc_m !== 3'd1) $display("FAIL flush_noop: got wc=%0d want 1", wc_m);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (dout_m !== 16'hF800 || dout_l !== 16'h001F) $display("FAIL flush_data: got %h/%h want f800/001f", dout_m, dout_l);
        else n_pass++;
        // Flush arriving with the completing beat must push exactly one word.
        for (int k = 0; k < 15; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'($urandom), 1'b1, 1'b0);
        n_total++;
        if (wc_m !== 3'd1 || pend_m !== 5'd0) $display("FAIL flush_with_last: got wc=%0d pend=%0d want 1 0", wc_m, pend_m);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (dout_m !== exp_dout_m || dout_l !== exp_dout_l)
            $display("FAIL flush_with_last_data: got %h/%h want %h/%h", dout_m, dout_l, exp_dout_m, exp_dout_l);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] val;
        for (int w = 1; w <= 4; w++) begin
            val = 16'(w);
            for (int k = 0; k < 16; k++) step(1'b1, val[15-k], 1'b0, 1'b0);
        end
        n_total++;
        if (full_m !== 1'b1 || wc_m !== 3'd4) $display("FAIL fill_full: got full=%b wc=%0d want 1 4", full_m, wc_m);
        else n_pass++;
        for (int k = 0; k < 16; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        n_total++;
        if (ovf_m !== 1'b1 || wc_m !== 3'd4 || pend_m !== 5'd0)
            $display("FAIL overflow_drop: got ovf=%b wc=%0d pend=%0d want 1 4 0", ovf_m, wc_m, pend_m);
        else n_pass++;
        // A same-cycle read does not make room for the beat or the flush.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_total++;
        if (dout_m !== 16'h0001 || wc_m !== 3'd3 || pend_m !== 5'd0)
            $display("FAIL full_rd_no_rescue: got dout=%h wc=%0d pend=%0d want 0001 3 0", dout_m, wc_m, pend_m);
        else n_pass++;
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            n_total++;
            if (dout_m !== 16'(i) || dout_l !== exp_dout_l)
                $display("FAIL drain_order: got %h/%h want %h/%h", dout_m, dout_l, 16'(i), exp_dout_l);
            else n_pass++;
        end
        n_total++;
        if (empty_m !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty_m);
        else n_pass++;
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (unf_m !== 1'b1 || dout_m !== 16'h0004) $display("FAIL underflow: got unf=%b dout=%h want 1 0004", unf_m, dout_m);
        else n_pass++;
        for (int k = 0; k < 16; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        n_total++;
        if (ovf_m !== 1'b1 || unf_m !== 1'b1 || dout_m !== exp_dout_m)
            $display("FAIL sticky: got ovf=%b unf=%b dout=%h want 1 1 %h", ovf_m, unf_m, dout_m, exp_dout_m);
        else n_pass++;
        // Assert reset between edges; outputs must clear before the next edge.
        @(negedge clk);
        #2;
        rst   = 1'b1;
        wr_en = 1'b0;
        flush = 1'b0;
        rd_en = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({dout_m, dout_l, full_m, empty_m, wc_m, pend_m, ovf_m, unf_m} !== {32'h0, 1'b0, 1'b1, 3'd0, 5'd0, 2'b00})
            $display("FAIL async_reset: got dout=%h wc=%0d pend=%0d empty=%b ovf=%b unf=%b",
                     dout_m, wc_m, pend_m, empty_m, ovf_m, unf_m);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 32; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        for (int w = 0; w < 3 * DEPTH; w++) begin
            for (int k = 0; k < 16; k++) begin
                step(1'b1, 1'($urandom), 1'b0, k == 15);
                n_total++;
                if (wc_m !== 3'd2) $display("FAIL wrap_count: got %0d want 2", wc_m);
                else n_pass++;
                if (k == 15) begin
                    n_total++;
                    if (dout_m !== exp_dout_m || dout_l !== exp_dout_l)
                        $display("FAIL wrap_data: got %h/%h want %h/%h", dout_m, dout_l, exp_dout_m, exp_dout_l);
                    else n_pass++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            n_total++;
            if (dout_m !== exp_dout_m || dout_l !== exp_dout_l)
                $display("FAIL wrap_drain: got %h/%h want %h/%h", dout_m, dout_l, exp_dout_m, exp_dout_l);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 39; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        n_total++;
        if (pend_m !== 5'd7 || wc_m !== 3'd2) $display("FAIL mid_setup: got pend=%0d wc=%0d want 7 2", pend_m, wc_m);
        else n_pass++;
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (pend_m !== 5'd0 || empty_m !== 1'b1) $display("FAIL mid_reset: got pend=%0d empty=%b want 0 1", pend_m, empty_m);
        else n_pass++;
        for (int k = 0; k < 16; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (dout_m !== exp_dout_m || dout_l !== exp_dout_l)
            $display("FAIL mid_newword: got %h/%h want %h/%h", dout_m, dout_l, exp_dout_m, exp_dout_l);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] got, want;
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 8) == 0, ($urandom % 3) == 0);
            got  = {dout_m, wc_m, pend_m, full_m, empty_m, ovf_m, unf_m, 4'h0};
            want = {exp_dout_m, 3'(m_words.size()), 5'(m_beats.size()),
                    m_words.size() == DEPTH, m_words.size() == 0, exp_ovf, exp_unf, 4'h0};
            n_total++;
            if (got !== want || dout_l !== exp_dout_l)
                $display("FAIL random_cycle%0d: got %h lsb=%h want %h lsb=%h", c, got, dout_l, want, exp_dout_l);
            else n_pass++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        din   = '0;
        wr_en = 1'b0;
        flush = 1'b0;
        rd_en = 1'b0;
        model_reset();
        test_reset();
        test_bit_order();
        test_flush();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
